// File: rtl/macc_frame_arbiter.sv
// Frame-locked round-robin arbiter sharing one Macc between NCH requesters; results come back tagged
// with their channel. Defining MACC_ARB_MAXLEN_EN caps frames at MAXLEN beats and enables overrun.
module macc_frame_arbiter #(
  parameter int  NCH    = 4,
  parameter int  ADW    = 24,
  parameter int  BDW    = 18,
  parameter int  ODW    = 48,
  parameter int  DEPTH  = 4,
  parameter int  MAXLEN = 256,
  localparam int IDW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*ADW-1:0] s_axis_atdata,
  input  logic [NCH*BDW-1:0] s_axis_btdata,
  input  logic [NCH-1:0]     s_axis_tvalid,
  input  logic [NCH-1:0]     s_axis_tlast,
  output logic [NCH-1:0]     s_axis_tready,
  output logic [ADW-1:0]     m_axis_atdata,
  output logic [BDW-1:0]     m_axis_btdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  input  logic [ODW-1:0]     s_res_tdata,
  input  logic               s_res_tvalid,
  output logic               s_res_tready,
  output logic [ODW-1:0]     m_res_tdata,
  output logic [IDW-1:0]     m_res_tid,
  output logic               m_res_tvalid,
  input  logic               m_res_tready,
  output logic               overrun
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;

  logic [IDW-1:0] pick;
  logic           pick_found;
  logic           busy, fifo_empty, fifo_full, push, pop, accept, force_last;
  logic [ADW-1:0] a_sel;
  logic [BDW-1:0] b_sel;
  logic           v_sel, l_sel;

  // First valid requester at or above rr_ptr, wrapping past NCH-1.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_found && s_axis_tvalid[idx]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  always_comb begin
    a_sel = s_axis_atdata[int'(grant_q)*ADW +: ADW];
    b_sel = s_axis_btdata[int'(grant_q)*BDW +: BDW];
    v_sel = s_axis_tvalid[grant_q];
    l_sel = s_axis_tlast[grant_q];
  end

  assign busy       = (state_q == BUSY);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(DEPTH));
  assign push       = (state_q == IDLE) && pick_found && !fifo_full;
  assign pop        = m_res_tvalid && m_res_tready;
  assign accept     = m_axis_tvalid && m_axis_tready;

  // Data is zeroed outside a frame so nothing leaks through while idle or in reset.
  assign m_axis_tvalid = busy && v_sel;
  assign m_axis_atdata = busy ? a_sel : '0;
  assign m_axis_btdata = busy ? b_sel : '0;
  assign m_axis_tlast  = busy && (l_sel || force_last);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign s_axis_tready[gi] = busy && (grant_q == IDW'(gi)) && m_axis_tready;
  end

  assign m_res_tvalid = s_res_tvalid && !fifo_empty;
  assign s_res_tready = m_res_tready && !fifo_empty;
  assign m_res_tdata  = fifo_empty ? '0 : s_res_tdata;
  assign m_res_tid    = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d  = BUSY;
          grant_d  = pick;
          rr_ptr_d = (pick == IDW'(NCH-1)) ? '0 : pick + 1'b1;
        end
      end
      BUSY: begin
        if (accept && m_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage needs no reset: entries are only read while count_q marks them live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pick;
  end

`ifdef MACC_ARB_MAXLEN_EN
  localparam int CW = $clog2(MAXLEN+1);

  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          overrun_q, overrun_d;

  assign force_last = (beat_cnt_q == CW'(MAXLEN-1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    overrun_d  = overrun_q;
    if (accept) begin
      beat_cnt_d = m_axis_tlast ? '0 : beat_cnt_q + 1'b1;
      if (force_last && !l_sel) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign force_last = 1'b0;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_macc_frame_arbiter.sv
// Scoreboard bench for macc_frame_arbiter with a behavioural in-order Macc behind it.
module tb_macc_frame_arbiter;
  localparam int NCH = 4, ADW = 24, BDW = 18, ODW = 48, DEPTH = 4, MAXLEN = 4, IDW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH*ADW-1:0] s_axis_atdata;
  logic [NCH*BDW-1:0] s_axis_btdata;
  logic [NCH-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [ADW-1:0]     m_axis_atdata;
  logic [BDW-1:0]     m_axis_btdata;
  logic               m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [ODW-1:0]     s_res_tdata, m_res_tdata;
  logic               s_res_tvalid, s_res_tready;
  logic [IDW-1:0]     m_res_tid;
  logic               m_res_tvalid, m_res_tready, overrun;

  always #5 clk = ~clk;

  macc_frame_arbiter #(.NCH(NCH), .ADW(ADW), .BDW(BDW), .ODW(ODW), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst),
    .s_axis_atdata(s_axis_atdata), .s_axis_btdata(s_axis_btdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_atdata(m_axis_atdata), .m_axis_btdata(m_axis_btdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_res_tdata(s_res_tdata), .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
    .m_res_tdata(m_res_tdata), .m_res_tid(m_res_tid), .m_res_tvalid(m_res_tvalid),
    .m_res_tready(m_res_tready), .overrun(overrun)
  );

  typedef struct {
    logic [ADW-1:0] a;
    logic [BDW-1:0] b;
    bit             last;
    int             gap;
  } beat_t;

  typedef struct {
    logic [IDW-1:0] tid;
    logic [ODW-1:0] data;
  } exp_t;

  beat_t          chq [NCH][$];
  exp_t           exp_q[$];
  logic [ODW-1:0] resq[$];

  int checks = 0;
  int errors = 0;

  // Handshakes sampled at the active edge; the negedge processes act on them.
  logic [NCH-1:0] fire_q = '0;
  logic           mfire_q = 1'b0, ml_q = 1'b0, rfire_q = 1'b0, ofire_q = 1'b0;
  logic [ADW-1:0] ma_q = '0;
  logic [BDW-1:0] mb_q = '0;
  logic [ODW-1:0] od_q = '0;
  logic [IDW-1:0] oid_q = '0;
  int             frames_done = 0;
  logic [NCH-1:0] mask1 = '0;
  logic           watch4 = 1'b0;
  logic           bad1 = 1'b0, bad4 = 1'b0;

  always @(posedge clk) begin
    fire_q  <= s_axis_tvalid & s_axis_tready;
    mfire_q <= m_axis_tvalid & m_axis_tready;
    ma_q    <= m_axis_atdata;
    mb_q    <= m_axis_btdata;
    ml_q    <= m_axis_tlast;
    rfire_q <= s_res_tvalid & s_res_tready;
    ofire_q <= m_res_tvalid & m_res_tready;
    od_q    <= m_res_tdata;
    oid_q   <= m_res_tid;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frames_done <= frames_done + 1;
    if ((s_axis_tready & mask1) != '0) bad1 <= 1'b1;
    if (watch4 && s_axis_tready[1] && chq[3].size() > 0) bad4 <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic put(input int c, input int a, input int b, input bit last, input int gap);
    beat_t bt;
    bt.a = ADW'(a);
    bt.b = BDW'(b);
    bt.last = last;
    bt.gap = gap;
    chq[c].push_back(bt);
  endtask

  task automatic expect_res(input int tid, input int data);
    exp_t e;
    e.tid = IDW'(tid);
    e.data = ODW'(data);
    exp_q.push_back(e);
  endtask

  // Requester drivers plus the in-order Macc model.
  task automatic driver();
    int gap_cnt[NCH];
    logic [ODW-1:0] acc;
    acc = '0;
    for (int c = 0; c < NCH; c++) gap_cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = '0;
        resq.delete();
      end else begin
        if (rfire_q && resq.size() > 0) void'(resq.pop_front());
        if (mfire_q) begin
          acc = acc + ODW'(ma_q) * ODW'(mb_q);
          if (ml_q) begin
            resq.push_back(acc);
            acc = '0;
          end
        end
      end
      s_res_tvalid = (resq.size() > 0);
      s_res_tdata  = (resq.size() > 0) ? resq[0] : '0;
      for (int c = 0; c < NCH; c++) begin
        if (fire_q[c] && chq[c].size() > 0) begin
          void'(chq[c].pop_front());
          gap_cnt[c] = 0;
        end
        if (chq[c].size() > 0 && gap_cnt[c] >= chq[c][0].gap) begin
          s_axis_tvalid[c] = 1'b1;
          s_axis_tlast[c]  = chq[c][0].last;
          s_axis_atdata[c*ADW +: ADW] = chq[c][0].a;
          s_axis_btdata[c*BDW +: BDW] = chq[c][0].b;
        end else begin
          s_axis_tvalid[c] = 1'b0;
          s_axis_tlast[c]  = 1'b0;
          if (chq[c].size() > 0) gap_cnt[c]++;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ofire_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(oid_q) + 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_tid", 64'(oid_q), 64'(e.tid));
          chk("res_data", 64'(od_q), 64'(e.data));
        end
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0) || (resq.size() > 0);
    for (int c = 0; c < NCH; c++) if (chq[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (pending() && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 64'(pending()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, 64'({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_res_tvalid, s_res_tready, overrun}), 64'd0);
    chk({name, "_data"}, 64'(|{m_axis_atdata, m_axis_btdata, m_res_tdata, m_res_tid}), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    s_axis_atdata = '0;
    s_axis_btdata = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_res_tdata   = '0;
    s_res_tvalid  = 1'b0;
    m_axis_tready = 1'b1;
    m_res_tready  = 1'b1;
    fork
      driver();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three contenders with two 2-beat frames each: rotation 0,1,3,0,1,3.
    put(0, 1, 1, 0, 0); put(0, 2, 1, 1, 0); put(0, 3, 2, 0, 0); put(0, 1, 2, 1, 0);
    put(1, 2, 2, 0, 0); put(1, 2, 3, 1, 0); put(1, 4, 4, 0, 0); put(1, 1, 1, 1, 0);
    put(3, 1, 5, 0, 0); put(3, 1, 6, 1, 0); put(3, 2, 2, 0, 0); put(3, 2, 2, 1, 0);
    expect_res(0, 3); expect_res(1, 10); expect_res(3, 11);
    expect_res(0, 8); expect_res(1, 17); expect_res(3, 8);
    wait_drain("rotation");

    // Lone requester on channel 2: 2*5+3*5+4*5 = 45.
    mask1 = 4'b1011;
    put(2, 2, 5, 0, 0); put(2, 3, 5, 0, 0); put(2, 4, 5, 1, 0);
    expect_res(2, 45);
    wait_drain("single");
    mask1 = '0;
    chk("single_other_ready", 64'(bad1), 64'd0);

    // Results held back: four grants fill the ID FIFO, the fifth frame must wait.
    m_res_tready = 1'b0;
    base = frames_done;
    put(0, 1, 1, 1, 0); put(1, 2, 1, 1, 0); put(2, 3, 1, 1, 0); put(3, 4, 1, 1, 0); put(0, 5, 1, 1, 0);
    expect_res(3, 4); expect_res(0, 1); expect_res(1, 2); expect_res(2, 3); expect_res(0, 5);
    repeat (20) @(negedge clk);
    chk("grants_while_full", 64'(frames_done - base), 64'd4);
    chk("stalled_ready", 64'(s_axis_tready), 64'd0);
    m_res_tready = 1'b1;
    n = 0;
    while ((frames_done - base) < 5 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_grant_after_pop", 64'(frames_done - base), 64'd5);
    wait_drain("full");

    // Channel 3 pauses 10 cycles mid-frame while channel 1 waits: no preemption.
    put(3, 1, 1, 0, 0); put(3, 2, 1, 0, 10); put(3, 3, 1, 1, 0);
    expect_res(3, 6);
    n = 0;
    while (chq[3].size() > 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    watch4 = 1'b1;
    put(1, 7, 2, 0, 0); put(1, 8, 2, 1, 0);
    expect_res(1, 30);
    wait_drain("hold");
    watch4 = 1'b0;
    chk("hold_ch1_ready", 64'(bad4), 64'd0);

    // Reset during beat 2 of a 4-beat frame; afterwards arbitration restarts from channel 0.
    put(0, 1, 1, 0, 0); put(0, 1, 1, 0, 0); put(0, 1, 1, 0, 0); put(0, 1, 1, 1, 0);
    n = 0;
    while (chq[0].size() > 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    chq[0].delete();
    #1;
    check_zero("midframe_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    put(2, 4, 4, 1, 0); put(1, 3, 3, 1, 0);
    expect_res(1, 9); expect_res(2, 16);
    wait_drain("after_reset");
    chk("overrun_clear", 64'(overrun), 64'd0);

`ifdef MACC_ARB_MAXLEN_EN
    // Six unit beats against a cap of four: results 4 then 2, overrun sticky.
    for (int i = 0; i < 6; i++) put(3, 1, 1, (i == 5), 0);
    expect_res(3, 4); expect_res(3, 2);
    wait_drain("maxlen");
    chk("overrun_set", 64'(overrun), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/macc_frame_arbiter.md
# macc_frame_arbiter

Frame-granular round-robin arbiter that shares one `Macc` instance between `NCH` requesters. Each requester presents a paired A/B stream, already aligned, framed by `tlast`. The arbiter locks the grant to one requester for a whole frame and records the granted channel in an ID FIFO. When `Macc` returns that frame's accumulator result, the arbiter tags it with the originating channel. It sits directly in front of `Macc`, in place of a per-channel `Macc` array.

## Interface
- `NCH`, 4: number of requesters (2..16).
- `ADW`, 24: A operand width.
- `BDW`, 18: B operand width.
- `ODW`, 48: result width.
- `DEPTH`, 4: ID FIFO depth, i.e. the maximum number of frames granted but not yet returned (power of two, ≥2).
- `MAXLEN`, 256: frame length cap; used only with `MACC_ARB_MAXLEN_EN`.
- `IDW`, `$clog2(NCH)`: channel ID width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axis_atdata`  in  NCH*ADW  per-requester A operand, packed with channel 0 in the LSBs.
- `s_axis_btdata`  in  NCH*BDW  per-requester B operand.
- `s_axis_tvalid`  in  NCH  per-requester beat valid (A and B together).
- `s_axis_tlast`  in  NCH  per-requester end of frame.
- `s_axis_tready`  out  NCH  per-requester ready; only the granted bit can be 1.
- `m_axis_atdata`  out  ADW  to `Macc` A.
- `m_axis_btdata`  out  BDW  to `Macc` B.
- `m_axis_tvalid`  out  1  to `Macc`.
- `m_axis_tlast`  out  1  to `Macc`.
- `m_axis_tready`  in  1  from `Macc`.
- `s_res_tdata`  in  ODW  `Macc` result.
- `s_res_tvalid`  in  1  `Macc` result valid.
- `s_res_tready`  out  1  to `Macc` result ready.
- `m_res_tdata`  out  ODW  tagged result.
- `m_res_tid`  out  IDW  originating channel of the result.
- `m_res_tvalid`  out  1  tagged result valid.
- `m_res_tready`  in  1  tagged result ready.
- `overrun`  out  1  sticky flag: a frame was truncated by `MAXLEN` (always 0 without the macro).

## Operation
- The FSM has two states, IDLE and BUSY. The registers are `grant` (IDW), `rr_ptr` (IDW), the ID FIFO and the beat counter.
- IDLE → BUSY when any `s_axis_tvalid` bit is 1 and `fifo_count < DEPTH`.
  - `grant` is the first valid channel searched from `rr_ptr` upward, wrapping at `NCH-1` → 0.
  - `grant` is pushed into the ID FIFO and `rr_ptr` becomes `grant+1` (mod NCH).
- A full FIFO blocks the grant even if a pop happens in the same cycle.
- In BUSY the data path is combinational.
  - `m_axis_*` are the granted channel's `atdata`, `btdata`, `tvalid` and `tlast`.
  - `s_axis_tready[grant] = m_axis_tready`; all other bits are 0.
- BUSY → IDLE on an accepted beat (`m_axis_tvalid && m_axis_tready`) with `m_axis_tlast=1`.
- In IDLE, `m_axis_tvalid=0` and all `s_axis_tready` bits are 0.
- Result path:
  - `m_res_tdata = s_res_tdata`.
  - `m_res_tid = fifo_head`.
  - `m_res_tvalid = s_res_tvalid && !fifo_empty`.
  - `s_res_tready = m_res_tready && !fifo_empty`.
  - The FIFO pops on `m_res_tvalid && m_res_tready`.
- A push and a pop in the same cycle (not full) both happen and the count is unchanged.
- A result that arrives while the FIFO is empty is stalled (ready 0) and is not dropped.
- Results return in grant order because `Macc` is in-order.

## Timing
- Reset: state IDLE, `grant=0`, `rr_ptr=0`, FIFO empty, counter 0, `overrun=0`. All outputs are 0 during reset.
- Arbitration costs 1 cycle per frame: the first beat can be accepted on the cycle after the grant decision.
- Back-to-back frames therefore have one idle cycle between the `tlast` beat and the next frame's first beat.
- Beat latency through the arbiter is 0 cycles (combinational). Result latency is 0 cycles plus the `Macc` latency.
- `s_axis_tvalid` dropping mid-frame on the granted channel holds the grant; there is no preemption.
- Asserting `rst` mid-frame discards the grant and all FIFO entries. The downstream `Macc` must share the same `rst`.

## Configuration
- `MACC_ARB_MAXLEN_EN` defined: a beat counter counts the accepted beats of the current frame.
  - On the `MAXLEN`-th accepted beat, `m_axis_tlast` is forced to 1 and BUSY → IDLE.
  - If the requester's own `tlast` was 0 on that beat, `overrun` sets and stays set until reset.
  - The requester's remaining beats form a new frame, which competes for arbitration normally.
- `MACC_ARB_MAXLEN_EN` undefined: no counter, `m_axis_tlast` is the granted channel's `tlast`, and `overrun` is tied to 0. Frames are unbounded.

## Test plan
- NCH=4, only channel 2 sends a 3-beat frame (a=2,3,4; b=5,5,5) → `m_res_tdata=45`, `m_res_tid=2`, `s_axis_tready[0,1,3]` stay 0 throughout.
- Channels 0,1,3 all hold 2-beat frames continuously → grant order 0,1,3,0,1,3 and `m_res_tid` follows the same order.
- `m_res_tready=0` while 5 single-beat frames are offered with DEPTH=4 → exactly 4 grants, the 5th requester stalls; one result accepted → 5th granted on the next IDLE cycle.
- Granted channel deasserts `tvalid` for 10 cycles mid-frame while channel 1 is valid → grant unchanged, channel 1 `tready=0`, frame completes correctly.
- `rst` pulse during beat 2 of a 4-beat frame → all outputs 0, FIFO empty, next frame granted to the lowest valid channel from `rr_ptr=0`.
- With `MACC_ARB_MAXLEN_EN`, MAXLEN=4, 6-beat frame of a=1, b=1 → results 4 then 2, `overrun=1`.
